// File: rtl/alarm_ctrl_pkg.sv
// Shared state encoding, defaults and width helpers for the alarm-clock keypad controller.
package alarm_ctrl_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    SHOW_ALARM       = 3'd1,
    KEY_STORED       = 3'd2,
    KEY_WAITED       = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  localparam int unsigned DEFAULT_NOKEY = 10;

  function automatic int unsigned sel_width(input int unsigned num_alarms);
    return (num_alarms <= 2) ? 1 : $clog2(num_alarms);
  endfunction

  function automatic int unsigned dc_width(input int unsigned num_digits);
    return $clog2(num_digits + 1);
  endfunction

endpackage

// File: rtl/key_timeout_timer.sv
// Counts one_second pulses while entry is active and flags the pulse that reaches the timeout.
module key_timeout_timer #(
  parameter int unsigned TIMEOUT_SECS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic one_second,
  output logic time_out
);

  // Sized to hold TIMEOUT_SECS: the count steps once more on the timeout pulse before clear lands.
  localparam int unsigned TW = $clog2(TIMEOUT_SECS + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && one_second) begin
      count <= count + TW'(1);
    end
  end

  assign time_out = enable && one_second && (count == TW'(TIMEOUT_SECS - 1));

endmodule

// File: rtl/alarm_ctrl_fsm.sv
// Keypad/button sequencer: captures digits into the key register and commits time or one of several alarms.
module alarm_ctrl_fsm
  import alarm_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_ALARMS   = 2,
  parameter  int unsigned NUM_DIGITS   = 4,
  parameter  int unsigned TIMEOUT_SECS = 10,
  parameter  int unsigned KEY_W        = 4,
  parameter  int unsigned NOKEY        = DEFAULT_NOKEY,
  localparam int unsigned SEL_W        = sel_width(NUM_ALARMS),
  localparam int unsigned DC_W         = dc_width(NUM_DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_second,
  input  logic [KEY_W-1:0]      key,
  input  logic                  alarm_button,
  input  logic                  time_button,
  input  logic [SEL_W-1:0]      alarm_sel,
  output logic                  shift,
  output logic                  show_new_time,
  output logic [NUM_ALARMS-1:0] show_a,
  output logic [NUM_ALARMS-1:0] load_new_a,
  output logic                  load_new_c,
  output logic                  reset_count,
  output logic [DC_W-1:0]       digit_count
);

  state_t           state;
  state_t           state_next;
  logic [SEL_W-1:0] alarm_idx;
  logic             capture_idx;
  logic             key_pressed;
  logic             digits_full;
  logic             sel_ok;
  logic             entry_timing;
  logic             timer_clear;
  logic             time_out;

  assign key_pressed  = (key != KEY_W'(NOKEY));
  assign digits_full  = (digit_count >= DC_W'(NUM_DIGITS));
  assign sel_ok       = (32'(alarm_sel) < NUM_ALARMS);
  assign entry_timing = (state == KEY_WAITED) || (state == KEY_ENTRY);
  // Releasing the key restarts the inactivity window.
  assign timer_clear  = !entry_timing || ((state == KEY_WAITED) && (state_next == KEY_ENTRY));

  key_timeout_timer #(
    .TIMEOUT_SECS(TIMEOUT_SECS)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (timer_clear),
    .enable     (entry_timing),
    .one_second (one_second),
    .time_out   (time_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SHOW_TIME;
      digit_count <= '0;
      alarm_idx   <= '0;
    end else begin
      state <= state_next;
      if (state == SHOW_TIME) begin
        digit_count <= '0;
      end else if ((state == KEY_STORED) && !digits_full) begin
        digit_count <= digit_count + DC_W'(1);
      end
      if (capture_idx) begin
        alarm_idx <= alarm_sel;
      end
    end
  end

  always_comb begin
    state_next  = state;
    capture_idx = 1'b0;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)     state_next = SHOW_ALARM;
        else if (key_pressed) state_next = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_next = SHOW_TIME;
      end
      KEY_STORED: state_next = KEY_WAITED;
      KEY_WAITED: begin
        if (time_out)         state_next = SHOW_TIME;
        else if (!key_pressed) state_next = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        if (time_out) begin
          state_next = SHOW_TIME;
        end else if (key_pressed && !digits_full) begin
          state_next = KEY_STORED;
        end else if (alarm_button && sel_ok) begin
          state_next  = SET_ALARM_TIME;
          capture_idx = 1'b1;
        end else if (time_button) begin
          state_next = SET_CURRENT_TIME;
        end
      end
      default: state_next = SHOW_TIME;
    endcase
  end

  always_comb begin
    shift         = (state == KEY_STORED);
    show_new_time = (state == KEY_STORED) || (state == KEY_WAITED) || (state == KEY_ENTRY);
    load_new_c    = (state == SET_CURRENT_TIME);
    reset_count   = (state == SET_CURRENT_TIME);
    show_a        = '0;
    load_new_a    = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      show_a[i]     = (state == SHOW_ALARM) && (32'(alarm_sel) == i);
      load_new_a[i] = (state == SET_ALARM_TIME) && (32'(alarm_idx) == i);
    end
  end

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs; a monitor compares them after each edge.
module tb_alarm_ctrl_fsm;

  localparam int unsigned NA = 3;
  localparam int unsigned ND = 4;
  localparam int unsigned TS = 10;
  localparam int unsigned KW = 4;
  localparam int unsigned NK = 10;
  localparam int unsigned SW = 2;
  localparam int unsigned DW = 3;
  localparam int unsigned OUT_W = 4 + 2 * NA + DW;

  // Model activity names (deliberately independent of the DUT's encoding)
  localparam int M_CLOCK_SHOWN = 100;
  localparam int M_ALARM_SHOWN = 101;
  localparam int M_DIGIT_TAKEN = 102;
  localparam int M_HOLDING     = 103;
  localparam int M_EDITING     = 104;
  localparam int M_STORE_ALARM = 105;
  localparam int M_STORE_TIME  = 106;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          one_second = 1'b0;
  logic [KW-1:0] key = KW'(NK);
  logic          alarm_button = 1'b0;
  logic          time_button = 1'b0;
  logic [SW-1:0] alarm_sel = '0;
  logic          shift, show_new_time, load_new_c, reset_count;
  logic [NA-1:0] show_a, load_new_a;
  logic [DW-1:0] digit_count;

  alarm_ctrl_fsm #(
    .NUM_ALARMS  (NA),
    .NUM_DIGITS  (ND),
    .TIMEOUT_SECS(TS),
    .KEY_W       (KW),
    .NOKEY       (NK)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .alarm_sel    (alarm_sel),
    .shift        (shift),
    .show_new_time(show_new_time),
    .show_a       (show_a),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .reset_count  (reset_count),
    .digit_count  (digit_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  string phase = "reset";

  logic [OUT_W-1:0] exp_q[$];
  string            tag_q[$];

  int mode   = M_CLOCK_SHOWN;
  int secs   = 0;
  int digits = 0;
  int idx    = 0;

  function automatic logic [OUT_W-1:0] dut_out();
    return {shift, show_new_time, show_a, load_new_a, load_new_c, reset_count, digit_count};
  endfunction

  function automatic logic [OUT_W-1:0] model_outputs(input int sel);
    logic [NA-1:0] sa;
    logic [NA-1:0] la;
    logic editing;
    sa = '0;
    la = '0;
    if (mode == M_ALARM_SHOWN && sel < int'(NA)) sa[sel] = 1'b1;
    if (mode == M_STORE_ALARM) la[idx] = 1'b1;
    editing = (mode == M_DIGIT_TAKEN) || (mode == M_HOLDING) || (mode == M_EDITING);
    return {mode == M_DIGIT_TAKEN, editing, sa, la, mode == M_STORE_TIME, mode == M_STORE_TIME, DW'(digits)};
  endfunction

  task automatic model_reset();
    mode   = M_CLOCK_SHOWN;
    secs   = 0;
    digits = 0;
    idx    = 0;
  endtask

  task automatic model_step(input bit os, input int k, input bit ab, input bit tbn, input int sel);
    bit in_entry;
    bit expired;
    bit pressed;
    int nxt;
    in_entry = (mode == M_HOLDING) || (mode == M_EDITING);
    expired  = in_entry && os && (secs == int'(TS) - 1);
    pressed  = (k != int'(NK));
    nxt = mode;
    if (mode == M_CLOCK_SHOWN) begin
      if (ab) nxt = M_ALARM_SHOWN;
      else if (pressed) nxt = M_DIGIT_TAKEN;
    end else if (mode == M_ALARM_SHOWN) begin
      if (!ab) nxt = M_CLOCK_SHOWN;
    end else if (mode == M_DIGIT_TAKEN) begin
      nxt = M_HOLDING;
    end else if (mode == M_HOLDING) begin
      if (expired) nxt = M_CLOCK_SHOWN;
      else if (!pressed) nxt = M_EDITING;
    end else if (mode == M_EDITING) begin
      if (expired) nxt = M_CLOCK_SHOWN;
      else if (pressed && digits < int'(ND)) nxt = M_DIGIT_TAKEN;
      else if (ab && sel < int'(NA)) begin
        nxt = M_STORE_ALARM;
        idx = sel;
      end else if (tbn) nxt = M_STORE_TIME;
    end else begin
      nxt = M_CLOCK_SHOWN;
    end
    if (!in_entry || (mode == M_HOLDING && nxt == M_EDITING)) secs = 0;
    else if (os) secs++;
    if (mode == M_CLOCK_SHOWN) digits = 0;
    else if (mode == M_DIGIT_TAKEN && digits < int'(ND)) digits++;
    mode = nxt;
  endtask

  task automatic compare(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: dut=%b expected=%b (shift,show_new_time,show_a,load_new_a,load_new_c,reset_count,digit_count)",
               name, $time, got, want);
    end
  endtask

  always @(posedge clock) begin : monitor
    logic [OUT_W-1:0] want;
    string            name;
    #2;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      name = tag_q.pop_front();
      compare(name, dut_out(), want);
    end
  end

  task automatic cycle(input bit os, input int k, input bit ab, input bit tbn, input int sel);
    @(negedge clock);
    reset        = 1'b0;
    one_second   = os;
    key          = KW'(k);
    alarm_button = ab;
    time_button  = tbn;
    alarm_sel    = SW'(sel);
    model_step(os, k, ab, tbn, sel);
    exp_q.push_back(model_outputs(sel));
    tag_q.push_back(phase);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, NK, 0, 0, 0);
  endtask

  task automatic digit(input int k);
    cycle(0, k, 0, 0, 0);
    idle(2);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset        = 1'b1;
    one_second   = 1'b0;
    key          = KW'(NK);
    alarm_button = 1'b0;
    time_button  = 1'b0;
    model_reset();
    #1 compare({phase, "_async_reset"}, dut_out(), model_outputs(int'(alarm_sel)));
    exp_q.push_back(model_outputs(int'(alarm_sel)));
    tag_q.push_back({phase, "_in_reset"});
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    int r;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    compare("reset_state", dut_out(), model_outputs(0));

    phase = "single_key";
    cycle(0, 3, 0, 0, 0);
    idle(4);
    pulse_reset();

    phase = "held_key";
    for (int i = 0; i < 20; i++) cycle(0, 5, 0, 0, 0);
    idle(3);
    pulse_reset();

    phase = "digit_limit";
    digit(1); digit(2); digit(3); digit(4);
    cycle(0, 7, 0, 0, 0);
    cycle(0, 7, 0, 0, 0);
    idle(2);
    cycle(0, NK, 0, 1, 0);
    idle(3);

    phase = "alarm_commit";
    digit(6); digit(8);
    cycle(0, NK, 1, 0, 1);
    idle(3);

    phase = "alarm_sel_out_of_range";
    digit(2); digit(9);
    for (int i = 0; i < 3; i++) cycle(0, NK, 1, 0, 3);
    idle(2);
    cycle(0, NK, 1, 1, 2);
    idle(3);

    phase = "timeout";
    digit(1);
    for (int i = 0; i < int'(TS); i++) begin
      cycle(1, NK, 0, 0, 0);
      idle(2);
    end
    idle(2);

    phase = "show_alarm";
    for (int i = 0; i < 3; i++) cycle(0, 4, 1, 0, 0);
    cycle(0, 4, 1, 0, 2);
    cycle(0, NK, 1, 0, 3);
    cycle(0, NK, 1, 0, 1);
    idle(3);

    phase = "reset_mid_entry";
    digit(3); digit(5);
    cycle(0, NK, 0, 0, 0);
    pulse_reset();
    idle(3);

    phase = "random";
    k = NK;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) k = NK;
      else if (r < 30) k = (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : NK);
      if (r == 99) pulse_reset();
      else cycle(($urandom_range(0, 2) == 0), k, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
    end
    idle(2);

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
